bit_pix_frame_writer: RTL

- Upstream feeder of block_matching_system's bit-pixel BRAM write port.
- Accepts a raster stream of 1-bit binarized pixels, 784 px/row × 480 rows, and splits each row into three vertical thirds: left 240 px, centre 304 px, right 240 px.
- Packs 16 pixels per word and generates the third index, in-third word address and double-buffer offset.
- Toggles the buffer and increments the image number at each completed frame; these feed the block-match control FSM.

---
 rtl/bit_pix_frame_writer.sv | 234 +++++++++++++++++++++++
 1 files changed

// File: rtl/bit_pix_frame_writer.sv
// -----------------------------------------------------------------------------
// bit_pix_frame_writer
//
// Purpose:
//   Feeds the bit-pixel BRAM write port of block_matching_system. A raster
//   stream of 1-bit pixels (ROW_W = 2*THIRD_WIDTH + CENTER_WIDTH pixels per
//   row, IMG_HEIGHT rows) is split into three vertical thirds (left, centre,
//   right). Pixels are packed WORD_W per word, first pixel in the LSB, and each
//   full word is written with its third index and an in-third word address that
//   includes the double-buffer offset. At every completed frame the buffer
//   index toggles and the image number increments.
//
// Handshake:
//   There is no backpressure. A pixel is accepted on every rising clock edge
//   where pix_valid_i is high; pix_sof_i and pix_eol_i are only meaningful
//   together with pix_valid_i. wr_write_o is a one-cycle strobe that asserts
//   in the cycle after the last pixel of a word is accepted; wr_address_o,
//   wr_third_o and wr_writedata_o are valid in that cycle and hold afterwards.
//
// Ports:
//   clk_i, reset_i       clock, synchronous active-high reset
//   pix_valid_i          pixel strobe
//   pix_data_i           binarized pixel
//   pix_sof_i            start of frame, marks pixel (0,0)
//   pix_eol_i            last pixel of a row (checked only with LINE_CHECK_EN)
//   wr_address_o         BRAM word address, buffer offset included
//   wr_third_o           0 = left, 1 = centre, 2 = right
//   wr_writedata_o       packed pixels
//   wr_write_o           one-cycle write strobe
//   buf_index_o          buffer currently being written
//   image_number_o       count of completed frames
//   frame_done_o         one-cycle pulse per completed frame
//   line_err_o           one-cycle pulse on row-length mismatch
//   dbg_state_o          FSM state (0 = IDLE, 1 = ACTIVE)
//
// Configuration:
//   LINE_CHECK_EN  when defined, a pix_eol_i that does not coincide with the
//                  last column (or is missing there) pulses line_err_o and
//                  aborts the frame. When undefined pix_eol_i is ignored and
//                  line_err_o stays 0.
// -----------------------------------------------------------------------------
module bit_pix_frame_writer #(
    parameter int THIRD_WIDTH  = 240,
    parameter int CENTER_WIDTH = 304,
    parameter int IMG_HEIGHT   = 480,
    parameter int WORD_W       = 16,
    parameter int IMG_NUM_W    = 32
) (
    input  logic                 clk_i,
    input  logic                 reset_i,
    input  logic                 pix_valid_i,
    input  logic                 pix_data_i,
    input  logic                 pix_sof_i,
    input  logic                 pix_eol_i,
    output logic [15:0]          wr_address_o,
    output logic [1:0]           wr_third_o,
    output logic [WORD_W-1:0]    wr_writedata_o,
    output logic                 wr_write_o,
    output logic                 buf_index_o,
    output logic [IMG_NUM_W-1:0] image_number_o,
    output logic                 frame_done_o,
    output logic                 line_err_o,
    output logic                 dbg_state_o
);

    localparam int ROW_W  = 2 * THIRD_WIDTH + CENTER_WIDTH;
    localparam int WPR_T  = THIRD_WIDTH / WORD_W;
    localparam int WPR_C  = CENTER_WIDTH / WORD_W;
    localparam int END_T  = WPR_T * IMG_HEIGHT;
    localparam int END_C  = WPR_C * IMG_HEIGHT;
    localparam int COL_W  = $clog2(ROW_W);
    localparam int ROWC_W = $clog2(IMG_HEIGHT);
    localparam int SH_W   = $clog2(WORD_W);

    typedef enum logic {
        S_IDLE   = 1'b0,
        S_ACTIVE = 1'b1
    } state_t;

    state_t                 state_q;
    logic [COL_W-1:0]       col_q;
    logic [ROWC_W-1:0]      row_q;
    logic [15:0]            rbase_t_q;   // row * WPR_T, kept incrementally
    logic [15:0]            rbase_c_q;   // row * WPR_C, kept incrementally
    logic [WORD_W-1:0]      shift_q;

    logic [15:0]            wr_address_q;
    logic [1:0]             wr_third_q;
    logic [WORD_W-1:0]      wr_writedata_q;
    logic                   wr_write_q;
    logic                   buf_q;
    logic [IMG_NUM_W-1:0]   image_number_q;
    logic                   frame_done_q;
    logic                   line_err_q;

    logic                   last_col;
    logic                   last_row;
    logic                   word_full;
    logic                   start_frame;
    logic                   line_bad;
    logic [SH_W-1:0]        pix_k;
    logic [1:0]             third_d;
    logic [COL_W-1:0]       third_start;
    logic [15:0]            rbase_sel;
    logic [15:0]            buf_off;
    logic [15:0]            wr_address_d;
    logic [WORD_W-1:0]      shift_d;

    // Thirds are multiples of WORD_W wide, so the column LSBs are the bit
    // position inside the current word.
    assign pix_k     = col_q[SH_W-1:0];
    assign word_full = &pix_k;
    assign last_col  = (col_q == COL_W'(ROW_W - 1));
    assign last_row  = (row_q == ROWC_W'(IMG_HEIGHT - 1));

    // A sof on the final pixel of a frame does not restart: that pixel
    // completes the frame and the next frame waits for a later sof.
    assign start_frame = pix_valid_i && pix_sof_i &&
                         ((state_q == S_IDLE) || !(last_col && last_row));

`ifdef LINE_CHECK_EN
    assign line_bad = (pix_eol_i != last_col);
`else
    assign line_bad = pix_eol_i & 1'b0;
`endif

    always_comb begin
        third_d     = 2'd0;
        third_start = '0;
        if (col_q >= COL_W'(THIRD_WIDTH + CENTER_WIDTH)) begin
            third_d     = 2'd2;
            third_start = COL_W'(THIRD_WIDTH + CENTER_WIDTH);
        end else if (col_q >= COL_W'(THIRD_WIDTH)) begin
            third_d     = 2'd1;
            third_start = COL_W'(THIRD_WIDTH);
        end

        rbase_sel = (third_d == 2'd1) ? rbase_c_q : rbase_t_q;
        buf_off   = 16'd0;
        if (buf_q) begin
            buf_off = (third_d == 2'd1) ? 16'(END_C) : 16'(END_T);
        end
        wr_address_d = buf_off + rbase_sel + 16'((col_q - third_start) >> SH_W);

        shift_d        = shift_q;
        shift_d[pix_k] = pix_data_i;
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q        <= S_IDLE;
            col_q          <= '0;
            row_q          <= '0;
            rbase_t_q      <= '0;
            rbase_c_q      <= '0;
            shift_q        <= '0;
            wr_address_q   <= '0;
            wr_third_q     <= '0;
            wr_writedata_q <= '0;
            wr_write_q     <= 1'b0;
            buf_q          <= 1'b0;
            image_number_q <= '0;
            frame_done_q   <= 1'b0;
            line_err_q     <= 1'b0;
        end else begin
            wr_write_q   <= 1'b0;
            frame_done_q <= 1'b0;
            line_err_q   <= 1'b0;

            // Buffer and image number advance one cycle after the final
            // write strobe, so the strobe itself still reports the old buffer.
            if (frame_done_q) begin
                buf_q          <= ~buf_q;
                image_number_q <= image_number_q + 1'b1;
            end

            if (start_frame) begin
                // Fresh frame or abort-and-restart: partial word is dropped
                // and this pixel becomes (0,0) in the same buffer.
                state_q   <= S_ACTIVE;
                shift_q   <= WORD_W'(pix_data_i);
                col_q     <= COL_W'(1);
                row_q     <= '0;
                rbase_t_q <= '0;
                rbase_c_q <= '0;
            end else if (pix_valid_i && (state_q == S_ACTIVE)) begin
                if (line_bad) begin
                    line_err_q <= 1'b1;
                    state_q    <= S_IDLE;
                    shift_q    <= '0;
                    col_q      <= '0;
                    row_q      <= '0;
                    rbase_t_q  <= '0;
                    rbase_c_q  <= '0;
                end else begin
                    shift_q <= word_full ? '0 : shift_d;
                    if (word_full) begin
                        wr_write_q     <= 1'b1;
                        wr_writedata_q <= shift_d;
                        wr_third_q     <= third_d;
                        wr_address_q   <= wr_address_d;
                    end
                    if (last_col) begin
                        col_q <= '0;
                        if (last_row) begin
                            state_q      <= S_IDLE;
                            frame_done_q <= 1'b1;
                            row_q        <= '0;
                            rbase_t_q    <= '0;
                            rbase_c_q    <= '0;
                        end else begin
                            row_q     <= row_q + 1'b1;
                            rbase_t_q <= rbase_t_q + 16'(WPR_T);
                            rbase_c_q <= rbase_c_q + 16'(WPR_C);
                        end
                    end else begin
                        col_q <= col_q + 1'b1;
                    end
                end
            end
        end
    end

    assign wr_address_o   = wr_address_q;
    assign wr_third_o     = wr_third_q;
    assign wr_writedata_o = wr_writedata_q;
    assign wr_write_o     = wr_write_q;
    assign buf_index_o    = buf_q;
    assign image_number_o = image_number_q;
    assign frame_done_o   = frame_done_q;
    assign line_err_o     = line_err_q;
    assign dbg_state_o    = (state_q == S_ACTIVE);

endmodule
